// File: rtl/spi_dma_bst_pkg.sv
// Shared definitions for the SPI DMA burst channels: FSM state encoding,
// status-word bit layout and small arithmetic helpers.
package spi_dma_bst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } dma_state_e;

  localparam int CST_STATE_LSB = 0;
  localparam int CST_ERR_BIT   = 2;
  localparam int CST_OUT_LSB   = 8;
  localparam int CST_OUT_W     = 8;
  localparam int CST_DFF_LSB   = 16;

  // An abort may clear the remaining count while a burst is still in flight,
  // so the acknowledge must not underflow it.
  function automatic logic [23:0] sat_sub24(input logic [23:0] a, input logic [23:0] b);
    sat_sub24 = (a > b) ? (a - b) : 24'd0;
  endfunction

endpackage

// File: rtl/spi_dma_rc_credit.sv
// Outstanding-read counter and destination FIFO free-space check for the
// read channel.
import spi_dma_bst_pkg::*;

module spi_dma_rc_credit #(
  parameter int BL = 4,
  parameter int FW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ack,
  input  logic [BL:0] ack_len,
  input  logic        rsp_val,
  input  logic [FW:0] dff_cnt,
  input  logic [BL:0] blen,
  output logic [FW:0] out_cnt,
  output logic        push,
  output logic        fits
);

  localparam logic [FW+1:0] FIFO_WORDS = {{(FW+1){1'b0}}, 1'b1} << FW;

  logic [FW:0]   out_cnt_r;
  logic [FW:0]   cnt_nxt_s;
  logic [FW+1:0] diff_s;
  logic [FW+1:0] free_s;

  assign push    = rsp_val && (out_cnt_r != {(FW+1){1'b0}});
  assign out_cnt = out_cnt_r;

  // A fill level beyond capacity shows up as a negative difference.
  assign diff_s = FIFO_WORDS - {1'b0, dff_cnt} - {1'b0, out_cnt_r};
  assign free_s = diff_s[FW+1] ? {(FW+2){1'b0}} : diff_s;
  assign fits   = ({{(FW-BL+1){1'b0}}, blen} <= free_s);

  // Next outstanding count: acknowledged words in, delivered words out.
  always_comb begin
    cnt_nxt_s = out_cnt_r;
    if (ack) begin
      cnt_nxt_s = cnt_nxt_s + (FW+1)'(ack_len);
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
    if (push) begin
      cnt_nxt_s = cnt_nxt_s - {{FW{1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // Outstanding-word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_r <= {(FW+1){1'b0}};
    end else begin
      out_cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/spi_dma_rc_bst.sv
// SPI DMA read channel: splits a PIO-programmed word count into bus read
// bursts sized by the bus limit and the free space of the destination FIFO.
import spi_dma_bst_pkg::*;

module spi_dma_rc_bst #(
  parameter int AL = 2,
  parameter int AW = 32,
  parameter int BL = 4,
  parameter int FW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pio_adr_we,
  input  logic          pio_len_we,
  input  logic [31:0]   pio_d,
  output logic [31:0]   pio_adr,
  output logic [31:0]   pio_len,
  output logic [31:0]   pio_cst,
  input  logic [BL:0]   burstcount,
  input  logic [FW:0]   dff_cnt,
  output logic          dff_we,
  output logic          dff_eof,
  output logic          done,
  output logic [AW-1:0] biu_adr,
  output logic [BL:0]   biu_len,
  output logic          biu_req,
  input  logic          biu_ack,
  input  logic          rsp_val
);

  dma_state_e       state_r, state_nxt_s;
  logic [AW-AL-1:0] adr_r;
  logic [23:0]      rem_r;
  logic [23:0]      rem_after_s;
  logic             err_r, done_r, biu_req_r;
  logic [AW-1:0]    biu_adr_r;
  logic [BL:0]      biu_len_r, blen_s;
  logic [FW:0]      out_cnt_s;
  logic             push_s, fits_s, ack_s, len_zero_s, abort_s, issue_s;
  logic [31:0]      cst_s;
  logic             unused_s;

  assign unused_s    = ^pio_d[AL-1:0];
  assign ack_s       = biu_ack && biu_req_r;
  assign len_zero_s  = (pio_d[23:0] == 24'd0);
  assign abort_s     = (state_r == REQ) && pio_len_we && len_zero_s;
  assign rem_after_s = sat_sub24(rem_r, 24'(biu_len_r));
  assign issue_s     = (state_r == REQ) && !biu_req_r && (blen_s != {(BL+1){1'b0}})
                       && fits_s && !abort_s;

  // Burst size is the smaller of the bus limit and the words still owed.
  always_comb begin
    if ({{(23-BL){1'b0}}, burstcount} <= rem_r) begin
      blen_s = burstcount;
    end else begin
      blen_s = rem_r[BL:0];
    end
  end

  spi_dma_rc_credit #(.BL(BL), .FW(FW)) u_credit (
    .clk     (clk),
    .rst     (rst),
    .ack     (ack_s),
    .ack_len (biu_len_r),
    .rsp_val (rsp_val),
    .dff_cnt (dff_cnt),
    .blen    (blen_s),
    .out_cnt (out_cnt_s),
    .push    (push_s),
    .fits    (fits_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pio_len_we && !len_zero_s) state_nxt_s = REQ;
        else                           state_nxt_s = IDLE;
      end
      REQ: begin
        if (abort_s)                                  state_nxt_s = DRAIN;
        else if (ack_s && (rem_after_s == 24'd0))     state_nxt_s = DRAIN;
        else                                          state_nxt_s = REQ;
      end
      DRAIN: begin
        if ((out_cnt_s == {(FW+1){1'b0}}) && !biu_req_r) state_nxt_s = IDLE;
        else                                             state_nxt_s = DRAIN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Address, remaining count, error flag, bus command and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_r     <= {(AW-AL){1'b0}};
      rem_r     <= 24'd0;
      err_r     <= 1'b0;
      biu_req_r <= 1'b0;
      biu_adr_r <= {AW{1'b0}};
      biu_len_r <= {(BL+1){1'b0}};
      done_r    <= 1'b0;
    end else begin
      if ((state_r == IDLE) && pio_adr_we) adr_r <= pio_d[AW-1:AL];
      else if (ack_s)                      adr_r <= adr_r + (AW-AL)'(biu_len_r);
      else                                 adr_r <= adr_r;

      if ((state_r == IDLE) && pio_len_we && !len_zero_s) rem_r <= pio_d[23:0];
      else if (abort_s)                                   rem_r <= 24'd0;
      else if (ack_s)                                     rem_r <= rem_after_s;
      else                                                rem_r <= rem_r;

      // A response with nothing outstanding is dropped and flagged.
      if (rsp_val && (out_cnt_s == {(FW+1){1'b0}})) err_r <= 1'b1;
      else if (pio_len_we)                          err_r <= 1'b0;
      else                                          err_r <= err_r;

      if (issue_s) begin
        biu_req_r <= 1'b1;
        biu_adr_r <= {adr_r, {AL{1'b0}}};
        biu_len_r <= blen_s;
      end else if (ack_s) begin
        biu_req_r <= 1'b0;
      end else begin
        biu_req_r <= biu_req_r;
      end

      done_r <= (state_r == DRAIN) && (state_nxt_s == IDLE);
    end
  end

  // Status word assembly.
  always_comb begin
    cst_s = 32'd0;
    cst_s[CST_STATE_LSB +: 2]         = state_r;
    cst_s[CST_ERR_BIT]                = err_r;
    cst_s[CST_OUT_LSB +: CST_OUT_W]   = CST_OUT_W'(out_cnt_s);
    cst_s[CST_DFF_LSB +: FW+1]        = dff_cnt;
  end

  assign pio_adr = 32'({adr_r, {AL{1'b0}}});
  assign pio_len = {8'd0, rem_r};
  assign pio_cst = cst_s;
  assign dff_we  = push_s && !rst;
  assign dff_eof = dff_we && (rem_r == 24'd0) && (out_cnt_s == {{FW{1'b0}}, 1'b1}) && !biu_req_r;
  assign done    = done_r;
  assign biu_req = biu_req_r;
  assign biu_adr = biu_adr_r;
  assign biu_len = biu_len_r;

endmodule

// File: tb/tb_spi_dma_rc_bst.sv
// Self-checking bench for spi_dma_rc_bst: the bench plays the bus and FIFO,
// and a word-level model predicts bursts, pushes, end-of-frame and status.
module tb_spi_dma_rc_bst;

  localparam int AL = 2, AW = 32, BL = 4, FW = 6;

  logic          clk, rst;
  logic          pio_adr_we, pio_len_we;
  logic [31:0]   pio_d, pio_adr, pio_len, pio_cst;
  logic [BL:0]   burstcount;
  logic [FW:0]   dff_cnt;
  logic          dff_we, dff_eof, done;
  logic [AW-1:0] biu_adr;
  logic [BL:0]   biu_len;
  logic          biu_req, biu_ack, rsp_val;

  int checks = 0, failures = 0;
  int pend, pushes, total, dones;
  bit err_exp;
  logic [31:0] exp_adr[$];
  int          exp_len[$];
  logic [31:0] exp_end;

  spi_dma_rc_bst #(.AL(AL), .AW(AW), .BL(BL), .FW(FW)) dut (
    .clk(clk), .rst(rst), .pio_adr_we(pio_adr_we), .pio_len_we(pio_len_we),
    .pio_d(pio_d), .pio_adr(pio_adr), .pio_len(pio_len), .pio_cst(pio_cst),
    .burstcount(burstcount), .dff_cnt(dff_cnt), .dff_we(dff_we), .dff_eof(dff_eof),
    .done(done), .biu_adr(biu_adr), .biu_len(biu_len), .biu_req(biu_req),
    .biu_ack(biu_ack), .rsp_val(rsp_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check status against the model, drive bus inputs, check pushes.
  task automatic cyc(input bit want_ack, input bit want_rsp);
    bit ack_now, push_exp, eof_exp;
    @(negedge clk);
    check("out_cnt", 32'(pio_cst[15:8]), 32'(pend));
    check("err", 32'(pio_cst[2]), 32'(err_exp));
    ack_now  = want_ack && biu_req;
    biu_ack  = ack_now;
    rsp_val  = want_rsp;
    push_exp = want_rsp && (pend > 0);
    eof_exp  = push_exp && (pushes == total - 1);
    #1;
    check("dff_we", 32'(dff_we), 32'(push_exp));
    check("dff_eof", 32'(dff_eof), 32'(eof_exp));
    if (push_exp) pushes++;
    if (done) dones++;
    if (ack_now) begin
      check("burst_avail", 32'(exp_adr.size() > 0), 32'd1);
      if (exp_adr.size() > 0) begin
        check("biu_adr", biu_adr, exp_adr[0]);
        check("biu_len", 32'(biu_len), 32'(exp_len[0]));
        check("credit", 32'(pend + int'(dff_cnt) + int'(biu_len) <= 64), 32'd1);
        void'(exp_adr.pop_front());
        void'(exp_len.pop_front());
      end
      pend = pend + int'(biu_len);
    end
    if (push_exp) pend = pend - 1;
    if (want_rsp && !push_exp) err_exp = 1'b1;
    else if (pio_len_we)       err_exp = 1'b0;
    @(posedge clk);
    #1;
    biu_ack = 1'b0;
    rsp_val = 1'b0;
  endtask

  task automatic start(input logic [31:0] adr, input int len, input int bc, input int dfc);
    logic [31:0] a;
    int r, b;
    burstcount = (BL+1)'(bc);
    dff_cnt    = (FW+1)'(dfc);
    exp_adr.delete();
    exp_len.delete();
    a = adr & 32'hFFFF_FFFC;
    r = len;
    while (r > 0) begin
      b = (bc < r) ? bc : r;
      exp_adr.push_back(a);
      exp_len.push_back(b);
      a = a + 32'(4 * b);
      r = r - b;
    end
    exp_end = a;
    total = len; pushes = 0; dones = 0;
    pio_d = adr; pio_adr_we = 1'b1; cyc(1'b0, 1'b0); pio_adr_we = 1'b0;
    pio_d = 32'(len); pio_len_we = 1'b1; cyc(1'b0, 1'b0); pio_len_we = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!biu_req && n < 40) begin cyc(1'b0, 1'b0); n++; end
    check(tag, 32'(biu_req), 32'd1);
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin
      cyc($urandom_range(0, 2) == 0, (pend > 0) && ($urandom_range(0, 1) == 1));
      n++;
    end
    check("done_seen", 32'(dones), 32'd1);
    repeat (3) cyc(1'b0, 1'b0);
    check("done_once", 32'(dones), 32'd1);
    check("pushes", 32'(pushes), 32'(total));
    check("pio_len_end", pio_len, 32'd0);
    check("state_end", 32'(pio_cst[1:0]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pio_adr_we = 1'b0; pio_len_we = 1'b0; pio_d = 32'd0;
    burstcount = '0; dff_cnt = '0; biu_ack = 1'b0; rsp_val = 1'b1;
    pend = 0; pushes = 0; total = 0; dones = 0; err_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dff_we", 32'(dff_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pio_adr", pio_adr, 32'd0);
    check("rst_pio_len", pio_len, 32'd0);
    check("rst_pio_cst", pio_cst, 32'd0);
    check("rst_biu_req", 32'(biu_req), 32'd0);
    check("rst_biu_len", 32'(biu_len), 32'd0);
    rsp_val = 1'b0;
    rst = 1'b0;

    // Nominal 40-word transfer: 16/16/8.
    start(32'h0000_1000, 40, 16, 0);
    run_to_done(2000);
    check("t1_adr", pio_adr, 32'h0000_10A0);
    check("t1_bursts", 32'(exp_adr.size()), 32'd0);

    // Stalls: zero burst limit, then a nearly full FIFO.
    start(32'h0000_2000, 16, 16, 50);
    burstcount = '0; dff_cnt = '0;
    repeat (5) begin cyc(1'b0, 1'b0); check("stall_bc0", 32'(biu_req), 32'd0); end
    burstcount = (BL+1)'(16); dff_cnt = (FW+1)'(50);
    repeat (8) begin cyc(1'b0, 1'b0); check("stall_full", 32'(biu_req), 32'd0); end
    dff_cnt = (FW+1)'(49);
    repeat (4) begin cyc(1'b0, 1'b0); check("stall_49", 32'(biu_req), 32'd0); end
    dff_cnt = (FW+1)'(48);
    wait_req("req_at_48");
    run_to_done(2000);
    check("t2_adr", pio_adr, 32'h0000_2040);

    // Acknowledge and response in the same cycle.
    start(32'h0000_3000, 32, 16, 0);
    wait_req("req1_t3");
    cyc(1'b1, 1'b0);
    repeat (13) cyc(1'b0, 1'b1);
    wait_req("req2_t3");
    check("out_is_3", 32'(pio_cst[15:8]), 32'd3);
    cyc(1'b1, 1'b1);
    check("out_is_18", 32'(pio_cst[15:8]), 32'd18);
    run_to_done(2000);

    // Abort while a request is pending.
    start(32'h0000_4000, 64, 16, 0);
    wait_req("req1_t4");
    cyc(1'b1, 1'b0);
    wait_req("req2_t4");
    pio_d = 32'd0; pio_len_we = 1'b1; cyc(1'b0, 1'b0); pio_len_we = 1'b0;
    check("abort_rem", pio_len, 32'd0);
    check("abort_pending", 32'(biu_req), 32'd1);
    check("abort_state", 32'(pio_cst[1:0]), 32'd2);
    total = 32;
    run_to_done(2000);
    check("t4_adr", pio_adr, 32'h0000_4080);

    // Response while idle is dropped and flagged.
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check("err_idle", 32'(pio_cst[2]), 32'd1);

    // Reset in the middle of a drain.
    start(32'h0000_5000, 16, 16, 0);
    wait_req("req_t5");
    cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1);
    check("t5_drain", 32'(pio_cst[1:0]), 32'd2);
    rst = 1'b1; pend = 0; err_exp = 1'b0;
    repeat (2) cyc(1'b0, 1'b0);
    rst = 1'b0;
    exp_adr.delete(); exp_len.delete();
    check("t5_pio_adr", pio_adr, 32'd0);
    check("t5_pio_len", pio_len, 32'd0);
    check("t5_pio_cst", pio_cst, 32'd0);
    check("t5_biu_req", 32'(biu_req), 32'd0);
    check("t5_biu_len", 32'(biu_len), 32'd0);
    dones = 0;
    repeat (10) cyc(1'b0, 1'b0);
    check("t5_no_done", 32'(dones), 32'd0);

    // Randomized transfers.
    repeat (8) begin
      logic [31:0] a;
      a = $urandom;
      start(a, $urandom_range(1, 60), $urandom_range(1, 16), $urandom_range(0, 40));
      run_to_done(4000);
      check("rnd_adr", pio_adr, exp_end);
      check("rnd_bursts", 32'(exp_adr.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_dma_rc_bst.md
SPI_DMA_RC_BST -- requirements
Module: spi_dma_rc_bst

Interface
REQ-001 SHALL have parameter AL, default 2: address LSB; data width is 8*(2**AL).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter BL, default 4: burst-length width; max burst is 2**BL words; BL>0.
REQ-004 SHALL have parameter FW, default 6: FIFO level width; FIFO size is 2**FW; FW>=BL.
REQ-005 SHALL have ports: clk in 1, single clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: pio_adr_we in 1, start-address write; pio_len_we in 1, length write; pio_d in 32, PIO write data.
REQ-007 SHALL have ports: pio_adr out 32, current byte address; pio_len out 32, remaining words; pio_cst out 32, status.
REQ-008 SHALL have ports: burstcount in BL+1, maximum burst size in words; dff_cnt in FW+1, destination FIFO fill level.
REQ-009 SHALL have ports: dff_we out 1, FIFO push; dff_eof out 1, last-word marker; done out 1, completion pulse.
REQ-010 SHALL have ports: biu_adr out AW, biu_len out BL+1, biu_req out 1 (read command); biu_ack in 1 (command accepted); rsp_val in 1 (read data valid).

Function
REQ-011 SHALL implement states IDLE, REQ and DRAIN.
REQ-012 SHALL load adr_reg from pio_d[AW-1:AL] on pio_adr_we while in IDLE, and ignore pio_adr_we otherwise.
REQ-013 SHALL, in IDLE, load rem_reg from pio_d[23:0] on pio_len_we and enter REQ when the value is nonzero; a zero write is ignored.
REQ-014 SHALL compute blen = min(burstcount, rem_reg); burstcount==0 stalls with no request.
REQ-015 SHALL compute free = 2**FW - dff_cnt - out_cnt at FW+2 bits, and treat negative as 0.
REQ-016 SHALL, in REQ with biu_req low and blen<=free and blen!=0, register biu_req=1 next cycle, with biu_adr={adr_reg,AL'b0} and biu_len=blen latched.
REQ-017 SHALL hold biu_req, biu_adr and biu_len stable until biu_ack, and deassert biu_req in the cycle after biu_ack.
REQ-018 SHALL, on biu_ack, add biu_len to adr_reg (wrapping modulo 2**(AW-AL)), subtract biu_len from rem_reg, and add biu_len to out_cnt.
REQ-019 SHALL, on rsp_val with out_cnt>0, assert dff_we combinationally in the same cycle and decrement out_cnt; simultaneous ack and rsp_val SHALL net out_cnt += biu_len-1.
REQ-020 SHALL, on rsp_val with out_cnt==0, drop the word (dff_we=0) and set sticky err (pio_cst[2]), cleared only by pio_len_we.
REQ-021 SHALL go REQ->DRAIN on the acknowledge that makes rem_reg 0.
REQ-022 SHALL treat pio_len_we with pio_d[23:0]==0 in REQ as an abort: clear rem_reg, stop new requests (a pending biu_req still completes), and enter DRAIN.
REQ-023 SHALL ignore nonzero pio_len_we outside IDLE.
REQ-024 SHALL go DRAIN->IDLE when out_cnt==0, with no pending request, and pulse done for exactly 1 cycle.
REQ-025 SHALL assert dff_eof with dff_we when rem_reg==0 and out_cnt==1 with no pending request.
REQ-026 SHALL drive pio_adr={adr_reg,AL'b0} and pio_len=rem_reg zero-extended.
REQ-027 SHALL drive pio_cst as follows: [1:0]=state, [2]=err, [15:8]=out_cnt, [16+:FW+1]=dff_cnt, other bits 0.

Reset
REQ-028 SHALL, on rst, asynchronously clear state to IDLE and clear adr_reg, rem_reg, out_cnt, err, biu_req and biu_len.
REQ-029 SHALL hold done, dff_we and dff_eof at 0 during reset.
REQ-030 SHALL, on reset mid-transfer, abandon outstanding responses, with no done pulse.

Structure
REQ-031 SHALL place the state enum and pio_cst bit offsets in shared package spi_dma_bst_pkg, which is also usable by the write channel.
REQ-032 SHALL isolate the out_cnt counter and free-space compare in one sub-module, spi_dma_rc_credit.

Verification
REQ-033 SHALL cover: AL=2, BL=4, FW=6, adr 0x1000, len 40, burstcount 16, dff_cnt 0 -> bursts 16/16/8 at 0x1000/0x1040/0x1080, 40 dff_we, dff_eof on 40th, done once.
REQ-034 SHALL cover: dff_cnt=50, out_cnt=0, len 16 -> no biu_req until dff_cnt<=48, then one burst of 16.
REQ-035 SHALL cover: biu_ack and rsp_val in the same cycle with out_cnt=3 and biu_len=16 -> out_cnt=18 next cycle.
REQ-036 SHALL cover: abort (pio_len_we, pio_d=0) while a request is pending, outstanding 16 -> the request completes, 32 pushes, then done, with rem=0.
REQ-037 SHALL cover: rsp_val in IDLE -> no dff_we and pio_cst[2]=1; after rst mid-DRAIN, all registers are 0 and no done pulse occurs.
